// File: rtl/alsa_sample_buffer.sv
// Elastic stereo FIFO between the host audio writer and the output mixer, with prefill gate and underrun recovery.
// Define ALSA_BUF_STATS_EN to add the 16-bit saturating underruns counter and its port.
module alsa_sample_buffer #(
  parameter int unsigned CLK_RATE   = 24576000,
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned PREFILL    = 128
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sample_rate,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [31:0]           wr_data,
  output logic                  wr_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic [15:0]           alsa_l,
  output logic [15:0]           alsa_r,
  output logic                  out_strobe,
`ifdef ALSA_BUF_STATS_EN
  output logic [15:0]           underruns,
`endif
  output logic                  playing
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] L_FULL    = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] L_PREFILL = (DEPTH_LOG2 + 1)'(PREFILL);
  localparam logic [31:0]         L_RATE    = 32'(CLK_RATE);

  typedef enum logic {S_PREFILL, S_PLAY} state_t;

  state_t                r_state;
  logic [31:0]           r_acc;
  logic [31:0]           w_accSum;
  logic                  w_tick;
  logic [31:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wrPtr;
  logic [DEPTH_LOG2-1:0] r_rdPtr;
  logic [DEPTH_LOG2-1:0] w_rdPtrNext;
  logic [DEPTH_LOG2:0]   r_level;
  logic [31:0]           r_rdData;
  logic [15:0]           r_alsaL;
  logic [15:0]           r_alsaR;
  logic                  r_strobe;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
`ifdef ALSA_BUF_STATS_EN
  logic [15:0]           r_underruns;
`endif

  assign w_accSum = r_acc + (sample_rate ? 32'd96000 : 32'd48000);
  assign w_tick   = (w_accSum >= L_RATE);
  assign w_empty  = (r_level == '0);
  assign wr_ready = (r_level != L_FULL);
  assign w_push   = wr_en & wr_ready & ~flush;
  assign w_pop    = (r_state == S_PLAY) & w_tick & ~w_empty & ~flush;

  assign level      = r_level;
  assign alsa_l     = r_alsaL;
  assign alsa_r     = r_alsaR;
  assign out_strobe = r_strobe;
  assign playing    = (r_state == S_PLAY);
`ifdef ALSA_BUF_STATS_EN
  assign underruns  = r_underruns;
`endif

  always_comb begin
    w_rdPtrNext = r_rdPtr;
    if (flush)
      w_rdPtrNext = '0;
    else if (w_pop)
      w_rdPtrNext = r_rdPtr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wrPtr] <= wr_data;
  end

  // Prefetch the head entry every cycle so a pop can load it with no extra latency;
  // a same-cycle write to the head slot is forwarded so the prefetch is never stale.
  always_ff @(posedge clk) begin
    if (w_push && (r_wrPtr == w_rdPtrNext))
      r_rdData <= wr_data;
    else
      r_rdData <= r_mem[w_rdPtrNext];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc     <= '0;
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_level   <= '0;
      r_state   <= S_PREFILL;
      r_alsaL   <= '0;
      r_alsaR   <= '0;
      r_strobe  <= 1'b0;
`ifdef ALSA_BUF_STATS_EN
      r_underruns <= '0;
`endif
    end else begin
      r_acc    <= w_tick ? (w_accSum - L_RATE) : w_accSum;
      r_strobe <= 1'b0;
      if (flush) begin
        r_wrPtr <= '0;
        r_rdPtr <= '0;
        r_level <= '0;
        r_state <= S_PREFILL;
        r_alsaL <= '0;
        r_alsaR <= '0;
      end else begin
        if (w_push)
          r_wrPtr <= r_wrPtr + 1'b1;
        r_rdPtr <= w_rdPtrNext;
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + 1'b1;
          2'b01:   r_level <= r_level - 1'b1;
          default: r_level <= r_level;
        endcase
        case (r_state)
          S_PREFILL: begin
            if (w_tick) begin
              r_strobe <= 1'b1;
              r_alsaL  <= '0;
              r_alsaR  <= '0;
            end
            if (r_level >= L_PREFILL)
              r_state <= S_PLAY;
          end
          S_PLAY: begin
            if (w_tick) begin
              r_strobe <= 1'b1;
              if (!w_empty) begin
                r_alsaL <= r_rdData[15:0];
                r_alsaR <= r_rdData[31:16];
              end else begin
                r_alsaL <= '0;
                r_alsaR <= '0;
                r_state <= S_PREFILL;
`ifdef ALSA_BUF_STATS_EN
                if (r_underruns != 16'hFFFF)
                  r_underruns <= r_underruns + 1'b1;
`endif
              end
            end
          end
          default: r_state <= S_PREFILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alsa_sample_buffer.sv
// Directed self-checking bench for alsa_sample_buffer at default parameters (48/96 kHz from 24.576 MHz).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_alsa_sample_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_rate;
  logic        flush;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic [8:0]  level;
  logic [15:0] alsa_l;
  logic [15:0] alsa_r;
  logic        out_strobe;
  logic        playing;
`ifdef ALSA_BUF_STATS_EN
  logic [15:0] underruns;
`endif

  int errCount   = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  alsa_sample_buffer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_rate (sample_rate),
    .flush       (flush),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .level       (level),
    .alsa_l      (alsa_l),
    .alsa_r      (alsa_r),
    .out_strobe  (out_strobe),
`ifdef ALSA_BUF_STATS_EN
    .underruns   (underruns),
`endif
    .playing     (playing)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One cycle of write-port stimulus, starting and ending on a falling edge.
  task automatic applyStimulus(input logic en, input logic [31:0] data);
    wr_en   = en;
    wr_data = data;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic waitStrobe(input int limit, output int gap);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!out_strobe && gap < limit);
    if (!out_strobe)
      checkOutput("strobeTimeout", 32'(gap), 32'(limit + 1));
  endtask

  function automatic logic [31:0] pairOf(input int i);
    return {16'(-i), 16'(i)};
  endfunction

  initial begin
    int gap;
    reset_n     = 1'b0;
    sample_rate = 1'b0;
    flush       = 1'b0;
    wr_en       = 1'b0;
    wr_data     = '0;
    repeat (3) @(negedge clk);
    checkOutput("resetLevel", 32'(level), 32'd0);
    checkOutput("resetWrReady", 32'(wr_ready), 32'd1);
    checkOutput("resetPlaying", 32'(playing), 32'd0);
    checkOutput("resetStrobe", 32'(out_strobe), 32'd0);
    checkOutput("resetOut", {alsa_r, alsa_l}, 32'd0);
`ifdef ALSA_BUF_STATS_EN
    checkOutput("resetUnderruns", 32'(underruns), 32'd0);
`endif
    reset_n = 1'b1;

    $display("[TB] prefill 128 pairs at 48 kHz");
    for (int i = 0; i < 128; i++)
      applyStimulus(1'b1, pairOf(i));
    checkOutput("prefillLevel", 32'(level), 32'd128);
    checkOutput("playingNotYet", 32'(playing), 32'd0);
    @(negedge clk);
    checkOutput("playingRises", 32'(playing), 32'd1);

    waitStrobe(1000, gap);
    checkOutput("pop0", {alsa_r, alsa_l}, pairOf(0));
    for (int i = 1; i < 4; i++) begin
      waitStrobe(1000, gap);
      checkOutput("gap48k", 32'(gap), 32'd512);
      checkOutput("pop48k", {alsa_r, alsa_l}, pairOf(i));
    end

    $display("[TB] switch to 96 kHz and drain");
    sample_rate = 1'b1;
    for (int i = 4; i < 128; i++) begin
      waitStrobe(600, gap);
      checkOutput("gap96k", 32'(gap), 32'd256);
      checkOutput("pop96k", {alsa_r, alsa_l}, pairOf(i));
    end
    checkOutput("drainedLevel", 32'(level), 32'd0);
    checkOutput("drainedPlaying", 32'(playing), 32'd1);
    waitStrobe(600, gap);
    checkOutput("underrunGap", 32'(gap), 32'd256);
    checkOutput("underrunOut", {alsa_r, alsa_l}, 32'd0);
    checkOutput("underrunPlaying", 32'(playing), 32'd0);
`ifdef ALSA_BUF_STATS_EN
    checkOutput("underrunCount", 32'(underruns), 32'd1);
`endif

    $display("[TB] refill and resume");
    for (int i = 0; i < 128; i++)
      applyStimulus(1'b1, {16'(16'h2000 + i), 16'(16'h1000 + i)});
    waitStrobe(600, gap);
    checkOutput("resumeGap", 32'(gap), 32'd128);
    checkOutput("resumePlaying", 32'(playing), 32'd1);
    checkOutput("resumePop0", {alsa_r, alsa_l}, 32'h2000_1000);
    waitStrobe(600, gap);
    checkOutput("resumePop1", {alsa_r, alsa_l}, 32'h2001_1001);

    $display("[TB] asynchronous reset mid-stream");
    #2 reset_n = 1'b0;
    #1;
    checkOutput("asyncLevel", 32'(level), 32'd0);
    checkOutput("asyncOut", {alsa_r, alsa_l}, 32'd0);
    checkOutput("asyncPlaying", 32'(playing), 32'd0);
    checkOutput("asyncWrReady", 32'(wr_ready), 32'd1);
`ifdef ALSA_BUF_STATS_EN
    checkOutput("asyncUnderruns", 32'(underruns), 32'd0);
`endif
    @(negedge clk);
    sample_rate = 1'b0;
    reset_n     = 1'b1;
    waitStrobe(1000, gap);
    checkOutput("firstTickAfterReset", 32'(gap), 32'd512);
    checkOutput("prefillStrobeOut", {alsa_r, alsa_l}, 32'd0);
    checkOutput("prefillStrobePlaying", 32'(playing), 32'd0);

    $display("[TB] fill to full depth");
    for (int i = 0; i < 256; i++)
      applyStimulus(1'b1, {16'(16'h4000 + i), 16'(16'h3000 + i)});
    checkOutput("fullLevel", 32'(level), 32'd256);
    checkOutput("fullWrReady", 32'(wr_ready), 32'd0);
    applyStimulus(1'b1, 32'hDEAD_BEEF);
    checkOutput("overflowLevel", 32'(level), 32'd256);
    waitStrobe(600, gap);
    checkOutput("fullPopGap", 32'(gap), 32'd255);
    checkOutput("fullPop0", {alsa_r, alsa_l}, 32'h4000_3000);
    checkOutput("fullPop0Level", 32'(level), 32'd255);
    checkOutput("fullPop0WrReady", 32'(wr_ready), 32'd1);
    waitStrobe(600, gap);
    checkOutput("fullPopGap2", 32'(gap), 32'd512);
    checkOutput("fullPop1", {alsa_r, alsa_l}, 32'h4001_3001);

    $display("[TB] flush against push and tick");
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flushLevel", 32'(level), 32'd0);
    checkOutput("flushPlaying", 32'(playing), 32'd0);
    checkOutput("flushOut", {alsa_r, alsa_l}, 32'd0);
    waitStrobe(600, gap);
    checkOutput("flushAlignGap", 32'(gap), 32'd511);
    for (int i = 1; i <= 510; i++) begin
      @(negedge clk);
      wr_en   = (i <= 50);
      wr_data = pairOf(1000 + i);
    end
    @(negedge clk);
    checkOutput("preFlushLevel", 32'(level), 32'd50);
    flush   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 32'h1234_5678;
    @(negedge clk);
    flush = 1'b0;
    wr_en = 1'b0;
    checkOutput("tickFlushLevel", 32'(level), 32'd0);
    checkOutput("tickFlushStrobe", 32'(out_strobe), 32'd0);
    checkOutput("tickFlushOut", {alsa_r, alsa_l}, 32'd0);
    checkOutput("tickFlushPlaying", 32'(playing), 32'd0);
`ifdef ALSA_BUF_STATS_EN
    checkOutput("tickFlushUnderruns", 32'(underruns), 32'd0);
`endif
    @(negedge clk);
    checkOutput("noLateStrobe", 32'(out_strobe), 32'd0);
    checkOutput("droppedPushLevel", 32'(level), 32'd0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
